// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage LoongArch pipeline.
// Registers the execute payload, captures the synchronous data-SRAM read
// result on the first occupied cycle, extracts and extends load data, and
// forwards the final result to writeback and to the decode bypass network.
//
// Ports:
//   clk, reset            core clock, synchronous active-high reset
//   ws_allowin            writeback can accept this cycle
//   ms_allowin            this stage can accept from execute
//   es_to_ms_valid/bus    execute payload (158 bits)
//   ms_to_ws_valid/bus    payload to writeback (152 bits)
//   ms_fwd_bus            {fwd_valid, blk_valid, dest[5], final_result[32]}
//   data_sram_rdata       SRAM read data, valid the cycle after the request
//   ms_flush_pipe         exception/ERTN flush from writeback
//   ms_ex                 valid syscall or ertn currently in this stage
module mem_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic         ws_allowin,
    output logic         ms_allowin,
    input  logic         es_to_ms_valid,
    input  logic [157:0] es_to_ms_bus,
    output logic         ms_to_ws_valid,
    output logic [151:0] ms_to_ws_bus,
    output logic [38:0]  ms_fwd_bus,
    input  logic [31:0]  data_sram_rdata,
    input  logic         ms_flush_pipe,
    output logic         ms_ex
);

    logic         ms_valid;
    logic         ms_ready_go;
    logic [157:0] es_to_ms_bus_r;
    logic         buf_valid;
    logic [31:0]  rdata_buf;

    logic [31:0]  csr_wvalue;
    logic         ertn;
    logic         syscall;
    logic         csr_re;
    logic         csr_we;
    logic [13:0]  csr_num;
    logic [31:0]  csr_wmask;
    logic [4:0]   load_op;
    logic         res_from_mem;
    logic         gr_we;
    logic [4:0]   dest;
    logic [31:0]  es_result;
    logic [31:0]  pc;

    logic [31:0]  mem_word;
    logic [1:0]   addr;
    logic [7:0]   ld_byte;
    logic [15:0]  ld_half;
    logic [31:0]  load_data;
    logic [31:0]  final_result;

    assign {csr_wvalue, ertn, syscall, csr_re, csr_we, csr_num, csr_wmask,
            load_op, res_from_mem, gr_we, dest, es_result, pc} = es_to_ms_bus_r;

    assign ms_ready_go    = 1'b1;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go && !ms_flush_pipe;

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid <= 1'b0;
        end else if (ms_flush_pipe) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (es_to_ms_valid && ms_allowin) begin
            es_to_ms_bus_r <= es_to_ms_bus;
        end
    end

    // The SRAM only presents read data for one cycle; hold it so a stalled
    // load keeps its result. Whenever ms_allowin is high the current
    // occupant (if any) leaves, so the buffer must not carry over.
    always_ff @(posedge clk) begin
        if (reset || ms_flush_pipe || ms_allowin) begin
            buf_valid <= 1'b0;
        end else if (ms_valid && !buf_valid) begin
            buf_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (ms_valid && !buf_valid && !ms_allowin) begin
            rdata_buf <= data_sram_rdata;
        end
    end

    assign mem_word = buf_valid ? rdata_buf : data_sram_rdata;
    assign addr     = es_result[1:0];

    always_comb begin
        ld_byte = 8'h00;
        case (addr)
            2'd0: ld_byte = mem_word[7:0];
            2'd1: ld_byte = mem_word[15:8];
            2'd2: ld_byte = mem_word[23:16];
            2'd3: ld_byte = mem_word[31:24];
            default: ld_byte = 8'h00;
        endcase
    end

    assign ld_half = addr[1] ? mem_word[31:16] : mem_word[15:0];

    always_comb begin
        load_data = 32'h0;
        case (1'b1)
            load_op[0]: load_data = {{24{ld_byte[7]}}, ld_byte};
            load_op[1]: load_data = {{16{ld_half[15]}}, ld_half};
            load_op[2]: load_data = mem_word;
            load_op[3]: load_data = {24'h0, ld_byte};
            load_op[4]: load_data = {16'h0, ld_half};
            default:    load_data = 32'h0;
        endcase
    end

    assign final_result = res_from_mem ? load_data : es_result;

    assign ms_to_ws_bus = {csr_wvalue, ertn, syscall, csr_re, csr_we, csr_num,
                           csr_wmask, gr_we, dest, final_result, pc};

    // blk_valid tells decode that the value is a CSR read, which is only
    // resolved in writeback, so it must stall rather than bypass.
    assign ms_fwd_bus = {ms_valid && gr_we, ms_valid && csr_re, dest, final_result};

    assign ms_ex = ms_valid && (syscall || ertn);

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a
// behavioural model of the stage (occupancy, first-cycle read word, load
// extraction by arithmetic).
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         ws_allowin;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [157:0] es_to_ms_bus;
    logic         ms_to_ws_valid;
    logic [151:0] ms_to_ws_bus;
    logic [38:0]  ms_fwd_bus;
    logic [31:0]  data_sram_rdata;
    logic         ms_flush_pipe;
    logic         ms_ex;

    int tests = 0;
    int fails = 0;

    // model state
    logic         m_valid = 1'b0;
    logic         m_first = 1'b0;
    logic [157:0] m_bus = '0;
    logic [31:0]  m_word = '0;

    localparam logic [4:0] OP_NONE = 5'b00000;
    localparam logic [4:0] OP_LDB  = 5'b00001;
    localparam logic [4:0] OP_LDH  = 5'b00010;
    localparam logic [4:0] OP_LDW  = 5'b00100;
    localparam logic [4:0] OP_LDBU = 5'b01000;
    localparam logic [4:0] OP_LDHU = 5'b10000;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk            (clk),
        .reset          (reset),
        .ws_allowin     (ws_allowin),
        .ms_allowin     (ms_allowin),
        .es_to_ms_valid (es_to_ms_valid),
        .es_to_ms_bus   (es_to_ms_bus),
        .ms_to_ws_valid (ms_to_ws_valid),
        .ms_to_ws_bus   (ms_to_ws_bus),
        .ms_fwd_bus     (ms_fwd_bus),
        .data_sram_rdata(data_sram_rdata),
        .ms_flush_pipe  (ms_flush_pipe),
        .ms_ex          (ms_ex)
    );

    function automatic logic [31:0] load_model(input logic [4:0] op, input logic [1:0] a,
                                               input logic [31:0] w);
        int unsigned b;
        int unsigned h;
        int unsigned sh;
        sh = 8 * int'(a);
        b  = (w >> sh) & 32'hFF;
        h  = (w >> (a[1] ? 16 : 0)) & 32'hFFFF;
        case (op)
            OP_LDB:  return (b >= 128) ? b - 256 : b;
            OP_LDH:  return (h >= 32768) ? h - 65536 : h;
            OP_LDW:  return w;
            OP_LDBU: return b;
            OP_LDHU: return h;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [157:0] mk(input logic [4:0] op, input logic rfm, input logic gwe,
                                        input logic [4:0] d, input logic [31:0] res,
                                        input logic cre, input logic sys, input logic ert);
        logic [31:0] wv, wm, pcv;
        logic [13:0] num;
        logic        cwe;
        wv  = $urandom;
        wm  = $urandom;
        pcv = $urandom;
        num = 14'($urandom);
        cwe = 1'($urandom);
        return {wv, ert, sys, cre, cwe, num, wm, op, rfm, gwe, d, res, pcv};
    endfunction

    function automatic logic [31:0] exp_final();
        logic [31:0] res;
        logic [31:0] w;
        res = m_bus[63:32];
        w   = m_first ? data_sram_rdata : m_word;
        return m_bus[70] ? load_model(m_bus[75:71], res[1:0], w) : res;
    endfunction

    task automatic check(input string tag, input logic [151:0] obs, input logic [151:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] fr;
        check("allowin", 152'(ms_allowin), 152'(!m_valid || ws_allowin));
        check("to_ws_valid", 152'(ms_to_ws_valid), 152'(m_valid && !ms_flush_pipe));
        check("ms_ex", 152'(ms_ex), 152'(m_valid && (m_bus[124] || m_bus[125])));
        check("fwd_flags", 152'(ms_fwd_bus[38:37]), 152'({m_valid && m_bus[69], m_valid && m_bus[123]}));
        if (m_valid) begin
            fr = exp_final();
            check("to_ws_bus", ms_to_ws_bus, {m_bus[157:76], m_bus[69], m_bus[68:64], fr, m_bus[31:0]});
            check("fwd_data", 152'(ms_fwd_bus[36:0]), 152'({m_bus[68:64], fr}));
        end
    endtask

    task automatic drive(input logic ev, input logic [157:0] b, input logic wa,
                         input logic [31:0] rd, input logic fl);
        es_to_ms_valid  = ev;
        es_to_ms_bus    = b;
        ws_allowin      = wa;
        data_sram_rdata = rd;
        ms_flush_pipe   = fl;
        #1;
        check_all();
    endtask

    // advance one clock, updating the model from the inputs seen at the edge
    task automatic tick();
        logic         nv, nf;
        logic [157:0] nb;
        logic [31:0]  nw;
        nv = m_valid; nf = m_first; nb = m_bus; nw = m_word;
        if (reset) begin
            nv = 1'b0;
            nf = 1'b0;
        end else if (!m_valid || ws_allowin) begin
            nv = es_to_ms_valid && !ms_flush_pipe;
            if (es_to_ms_valid) begin
                nb = es_to_ms_bus;
                nf = 1'b1;
            end
        end else if (ms_flush_pipe) begin
            nv = 1'b0;
        end else if (m_first) begin
            nw = data_sram_rdata;
            nf = 1'b0;
        end
        @(posedge clk);
        m_valid = nv; m_first = nf; m_bus = nb; m_word = nw;
        #1;
    endtask

    initial begin
        logic [157:0] b;
        logic [4:0]   op;
        logic         rfm;
        reset = 1'b1;
        es_to_ms_valid = 1'b0; es_to_ms_bus = '0; ws_allowin = 1'b1;
        data_sram_rdata = '0; ms_flush_pipe = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        drive(1'b0, '0, 1'b1, 32'h0, 1'b0);
        check("rst_to_ws_valid", 152'(ms_to_ws_valid), 152'(0));
        check("rst_fwd_flags", 152'(ms_fwd_bus[38:37]), 152'(0));
        check("rst_ex", 152'(ms_ex), 152'(0));
        check("rst_allowin", 152'(ms_allowin), 152'(1));
        tick();

        // load extraction
        drive(1'b1, mk(OP_LDB, 1, 1, 5'd3, 32'h1003, 0, 0, 0), 1'b1, 32'h0, 1'b0);
        tick();
        drive(1'b1, mk(OP_LDBU, 1, 1, 5'd4, 32'h1001, 0, 0, 0), 1'b1, 32'h80FF1234, 1'b0);
        check("ld_b", 152'(ms_to_ws_bus[63:32]), 152'(32'hFFFFFF80));
        tick();
        drive(1'b1, mk(OP_LDH, 1, 1, 5'd4, 32'h2002, 0, 0, 0), 1'b1, 32'h80FF1234, 1'b0);
        check("ld_bu", 152'(ms_to_ws_bus[63:32]), 152'(32'h00000012));
        tick();
        drive(1'b1, mk(OP_LDHU, 1, 1, 5'd4, 32'h2002, 0, 0, 0), 1'b1, 32'h80FF1234, 1'b0);
        check("ld_h", 152'(ms_to_ws_bus[63:32]), 152'(32'hFFFF80FF));
        tick();
        drive(1'b1, mk(OP_LDW, 1, 1, 5'd4, 32'h2002, 0, 0, 0), 1'b1, 32'h80FF1234, 1'b0);
        check("ld_hu", 152'(ms_to_ws_bus[63:32]), 152'(32'h000080FF));
        tick();
        drive(1'b1, mk(OP_LDW, 1, 1, 5'd6, 32'h3000, 0, 0, 0), 1'b1, 32'h80FF1234, 1'b0);
        check("ld_w", 152'(ms_to_ws_bus[63:32]), 152'(32'h80FF1234));
        tick();

        // stall with changing SRAM data
        drive(1'b0, '0, 1'b0, 32'h11223344, 1'b0);
        check("stall_entry", 152'(ms_to_ws_bus[63:32]), 152'(32'h11223344));
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b0, 32'hDEADBEEF, 1'b0);
            check("stall_hold", 152'(ms_to_ws_bus[63:32]), 152'(32'h11223344));
            check("stall_valid", 152'(ms_to_ws_valid), 152'(1));
            tick();
        end
        drive(1'b0, '0, 1'b1, 32'hDEADBEEF, 1'b0);
        check("stall_release", 152'(ms_to_ws_bus[63:32]), 152'(32'h11223344));
        tick();

        // forwarding
        drive(1'b1, mk(OP_NONE, 0, 1, 5'd5, 32'h1234, 0, 0, 0), 1'b1, 32'h0, 1'b0);
        tick();
        drive(1'b1, mk(OP_NONE, 0, 0, 5'd7, 32'h77, 1, 0, 0), 1'b1, 32'h0, 1'b0);
        check("fwd_alu", 152'(ms_fwd_bus), 152'({1'b1, 1'b0, 5'd5, 32'h00001234}));
        tick();
        drive(1'b1, mk(OP_NONE, 0, 0, 5'd0, 32'h0, 0, 1, 0), 1'b1, 32'h0, 1'b0);
        check("blk_valid", 152'(ms_fwd_bus[37]), 152'(1));
        tick();

        // syscall then flush with a simultaneous incoming instruction
        drive(1'b1, mk(OP_LDW, 1, 1, 5'd9, 32'h40, 0, 0, 0), 1'b1, 32'h0, 1'b1);
        check("syscall_ex", 152'(ms_ex), 152'(1));
        check("flush_to_ws", 152'(ms_to_ws_valid), 152'(0));
        tick();
        drive(1'b0, '0, 1'b1, 32'h0, 1'b0);
        check("flush_empty_valid", 152'(ms_to_ws_valid), 152'(0));
        check("flush_empty_fwd", 152'(ms_fwd_bus[38]), 152'(0));
        tick();

        // back-to-back loads
        drive(1'b1, mk(OP_LDW, 1, 1, 5'd10, 32'h100, 0, 0, 0), 1'b1, 32'h0, 1'b0);
        tick();
        drive(1'b1, mk(OP_LDW, 1, 1, 5'd11, 32'h104, 0, 0, 0), 1'b1, 32'hA, 1'b0);
        check("b2b_a", 152'(ms_to_ws_bus[63:32]), 152'(32'hA));
        tick();
        drive(1'b0, '0, 1'b1, 32'hB, 1'b0);
        check("b2b_b", 152'(ms_to_ws_bus[63:32]), 152'(32'hB));
        tick();

        // reset in the middle of a stall
        drive(1'b1, mk(OP_LDW, 1, 1, 5'd12, 32'h200, 0, 1, 0), 1'b1, 32'h0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 32'h55, 1'b0);
        tick();
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, 32'h66, 1'b0);
        tick();
        reset = 1'b0;
        drive(1'b0, '0, 1'b0, 32'h0, 1'b0);
        check("rst_stall_valid", 152'(ms_to_ws_valid), 152'(0));
        check("rst_stall_fwd", 152'(ms_fwd_bus[38:37]), 152'(0));
        check("rst_stall_ex", 152'(ms_ex), 152'(0));
        tick();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rfm = 1'($urandom);
            case ($urandom_range(5, 0))
                0: op = OP_LDB;
                1: op = OP_LDH;
                2: op = OP_LDW;
                3: op = OP_LDBU;
                4: op = OP_LDHU;
                default: op = rfm ? OP_LDW : OP_NONE;
            endcase
            b = mk(op, rfm, 1'($urandom), 5'($urandom), $urandom, ($urandom_range(7, 0) == 0),
                   ($urandom_range(15, 0) == 0), ($urandom_range(15, 0) == 0));
            drive(1'($urandom), b, ($urandom_range(9, 0) < 7), $urandom, ($urandom_range(19, 0) == 0));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
